// File: rtl/fc_backprop_serial.sv
// fc_backprop_serial: serial backward pass dX[j] = sum_i W[i][j]*G[i].
// Define FC_BP_SAT_EN for a wide accumulator that saturates dX on output.
module fc_backprop_serial #(
  parameter int WORD_SIZE  = 16,
  parameter int LAYER_SIZE = 128,
  parameter int FRAC_BITS  = 8
) (
  input  logic                                      clk,
  input  logic                                      rst,
  input  logic                                      g_valid,
  output logic                                      g_ready,
  input  logic [WORD_SIZE-1:0]                      g_data,
  output logic                                      w_rd_en,
  output logic [$clog2(LAYER_SIZE*LAYER_SIZE)-1:0] w_addr,
  input  logic [WORD_SIZE-1:0]                      w_data,
  output logic                                      dx_valid,
  input  logic                                      dx_ready,
  output logic [WORD_SIZE-1:0]                      dx_data,
  output logic [$clog2(LAYER_SIZE)-1:0]             dx_index,
  output logic                                      busy,
  output logic                                      done
);

  localparam int N  = LAYER_SIZE;
  localparam int W  = WORD_SIZE;
  localparam int CW = $clog2(N);
  localparam int AD = $clog2(N*N);
`ifdef FC_BP_SAT_EN
  localparam int AW = W + CW + 1;
`else
  localparam int AW = W;
`endif

  typedef enum logic [2:0] {
    LOAD,
    ISSUE,
    DRAIN,
    EMIT,
    FINISH
  } state_t;

  state_t              state;
  logic [CW-1:0]       cnt;
  logic [CW-1:0]       i;
  logic [CW-1:0]       j;
  logic [CW-1:0]       i_q;
  logic                rd_q;
  logic signed [AW-1:0] acc;
  logic signed [AW-1:0] acc_nxt;
  logic signed [W-1:0]  prod_w;
  logic [W-1:0]        gbuf [N];

  // Fixed-point product, truncated toward zero on the magnitude.
  function automatic logic signed [W-1:0] tprod(
    input logic signed [W-1:0] a,
    input logic signed [W-1:0] b
  );
    logic signed [2*W-1:0] p;
    logic [2*W-1:0]        mag;
    logic [W-1:0]          m;
    p   = a * b;
    mag = p[2*W-1] ? -p : p;
    m   = mag[FRAC_BITS+W-1:FRAC_BITS];
    return p[2*W-1] ? $signed(-m) : $signed(m);
  endfunction

`ifdef FC_BP_SAT_EN
  localparam logic signed [AW-1:0] SMAX = AW'((1 << (W-1)) - 1);
  localparam logic signed [AW-1:0] SMIN = ~SMAX;

  // Clamp the wide accumulator into the word range.
  function automatic logic [W-1:0] fmt(input logic signed [AW-1:0] v);
    if (v > SMAX) return SMAX[W-1:0];
    if (v < SMIN) return SMIN[W-1:0];
    return v[W-1:0];
  endfunction
`else
  // Wrapping accumulator is already word wide.
  function automatic logic [W-1:0] fmt(input logic signed [AW-1:0] v);
    return W'(v);
  endfunction
`endif

  // Next accumulator value: add the product of last cycle's read.
  always_comb begin
    prod_w  = tprod($signed(w_data), $signed(gbuf[i_q]));
    acc_nxt = acc;
    if (rd_q) acc_nxt = acc + AW'(prod_w);
  end

  // Gradient buffer capture during LOAD.
  always_ff @(posedge clk) begin
    if (!rst && state == LOAD && g_valid && g_ready)
      gbuf[cnt] <= g_data;
  end

  // Control FSM with registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= LOAD;
      g_ready  <= 1'b0;
      w_rd_en  <= 1'b0;
      w_addr   <= '0;
      dx_valid <= 1'b0;
      dx_data  <= '0;
      dx_index <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      cnt      <= '0;
      i        <= '0;
      j        <= '0;
      i_q      <= '0;
      rd_q     <= 1'b0;
      acc      <= '0;
    end else begin
      rd_q <= w_rd_en;
      i_q  <= i;
      acc  <= acc_nxt;
      done <= 1'b0;
      unique case (state)
        LOAD: begin
          g_ready <= 1'b1;
          busy    <= 1'b0;
          if (g_valid && g_ready) begin
            cnt <= cnt + 1'b1;
            if (cnt == CW'(N-1)) begin
              cnt     <= '0;
              g_ready <= 1'b0;
              busy    <= 1'b1;
              i       <= '0;
              j       <= '0;
              acc     <= '0;
              w_rd_en <= 1'b1;
              w_addr  <= '0;
              state   <= ISSUE;
            end
          end
        end
        ISSUE: begin
          if (i == CW'(N-1)) begin
            w_rd_en <= 1'b0;
            state   <= DRAIN;
          end else begin
            i      <= i + 1'b1;
            w_addr <= w_addr + AD'(N);
          end
        end
        DRAIN: begin
          dx_valid <= 1'b1;
          dx_data  <= fmt(acc_nxt);
          dx_index <= j;
          state    <= EMIT;
        end
        EMIT: begin
          if (dx_ready) begin
            dx_valid <= 1'b0;
            if (j == CW'(N-1)) begin
              done  <= 1'b1;
              state <= FINISH;
            end else begin
              j       <= j + 1'b1;
              i       <= '0;
              acc     <= '0;
              w_rd_en <= 1'b1;
              w_addr  <= AD'(j) + AD'(1);
              state   <= ISSUE;
            end
          end
        end
        FINISH: begin
          busy    <= 1'b0;
          g_ready <= 1'b1;
          state   <= LOAD;
        end
        default: state <= LOAD;
      endcase
    end
  end

endmodule

// File: tb/tb_fc_backprop_serial.sv
// tb_fc_backprop_serial: random and directed checks of fc_backprop_serial
// against an arithmetic reference model (N=4, Q8.8).
module tb_fc_backprop_serial;

  localparam int N  = 4;
  localparam int W  = 16;
  localparam int AD = 4;
  localparam int CW = 2;

  logic          clk = 1'b0;
  logic          rst;
  logic          g_valid;
  logic          g_ready;
  logic [W-1:0]  g_data;
  logic          w_rd_en;
  logic [AD-1:0] w_addr;
  logic [W-1:0]  w_data = '0;
  logic          dx_valid;
  logic          dx_ready;
  logic [W-1:0]  dx_data;
  logic [CW-1:0] dx_index;
  logic          busy;
  logic          done;

  logic [W-1:0] wmem [N*N];
  logic [W-1:0] gv   [N];
  logic [W-1:0] expv [N];

  int checks = 0;
  int errors = 0;

  fc_backprop_serial #(
    .WORD_SIZE (W),
    .LAYER_SIZE(N),
    .FRAC_BITS (8)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .g_valid (g_valid),
    .g_ready (g_ready),
    .g_data  (g_data),
    .w_rd_en (w_rd_en),
    .w_addr  (w_addr),
    .w_data  (w_data),
    .dx_valid(dx_valid),
    .dx_ready(dx_ready),
    .dx_data (dx_data),
    .dx_index(dx_index),
    .busy    (busy),
    .done    (done)
  );

  always #5 clk = ~clk;

  // Synchronous weight RAM, one cycle read latency.
  always @(posedge clk) begin
    if (w_rd_en) w_data <= wmem[w_addr];
  end

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got=%h want=%h", tag, got, want);
    end
  endtask

  function automatic logic [31:0] outs();
    return {5'b0, g_ready, w_rd_en, w_addr, dx_valid,
            dx_data, dx_index, busy, done};
  endfunction

  // dX[j] = sum_i trunc0(W[i][j]*G[i] / 256), kept to 16 magnitude bits.
  function automatic logic [W-1:0] model(input int j);
    int s, w, g, p, q, a, v;
    logic [W-1:0] v16;
    s = 0;
    for (int i = 0; i < N; i++) begin
      w = $signed(wmem[i*N+j]);
      g = $signed(gv[i]);
      p = w * g;
      q = p / 256;
      a = (q < 0) ? -q : q;
      a = a % 65536;
      v = (q < 0) ? -a : a;
      v16 = v[15:0];
      s = s + $signed(v16);
    end
`ifdef FC_BP_SAT_EN
    if (s > 32767) s = 32767;
    if (s < -32768) s = -32768;
`endif
    return s[15:0];
  endfunction

  task automatic set_all(input logic [W-1:0] wv, input logic [W-1:0] gg);
    for (int k = 0; k < N*N; k++) wmem[k] = wv;
    for (int k = 0; k < N; k++) gv[k] = gg;
  endtask

  task automatic set_rand();
    for (int k = 0; k < N*N; k++) wmem[k] = W'($urandom);
    for (int k = 0; k < N; k++) gv[k] = W'($urandom);
  endtask

  task automatic load_g(input bit throttle);
    int k = 0;
    int t = 0;
    while (k < N && t < 200) begin
      @(negedge clk);
      t++;
      g_valid = throttle ? t[0] : 1'b1;
      g_data  = gv[k];
      if (g_valid && g_ready) k++;
    end
    check("load_words", k, N);
  endtask

  task automatic run_vec(input bit throttle, input int stall);
    int cyc = 0;
    int first_rd = -1;
    int got = 0;
    int dones = 0;
    int sl = stall;
    int after = 0;
    bit post = 0;
    bit latdone = 0;
    for (int k = 0; k < N; k++) expv[k] = model(k);
    load_g(throttle);
    while (cyc < 300 && after < 4) begin
      @(negedge clk);
      cyc++;
      if (done) dones++;
      if (busy) check("gready_busy", g_ready, 0);
      if (cyc == 1) check("issue_start", w_rd_en, 1);
      if (first_rd < 0 && w_rd_en) first_rd = cyc;
      if (post) begin
        check("post_rd", {w_rd_en, w_addr}, {1'b1, 4'd1});
        post = 0;
      end
      if (got == N) after++;
      if (dx_valid) begin
        if (!latdone) begin
          latdone = 1;
          check("latency", cyc - first_rd + 1, N + 2);
        end
        if (sl > 0) begin
          check("stall_data", dx_data, expv[0]);
          check("stall_idx", dx_index, 0);
          check("stall_rd", w_rd_en, 0);
          sl--;
          dx_ready = 1'b0;
        end else begin
          dx_ready = (stall > 0) ? 1'b1 : 1'($urandom_range(0, 1));
          if (dx_ready) begin
            check("dx_idx", dx_index, got);
            check("dx_data", dx_data, expv[got]);
            if (stall > 0 && got == 0) post = 1;
            got++;
          end
        end
      end else begin
        dx_ready = 1'($urandom_range(0, 1));
      end
      g_valid = (got < N) ? 1'($urandom_range(0, 1)) : 1'b0;
      g_data  = W'($urandom);
    end
    check("dx_count", got, N);
    check("done_pulses", dones, 1);
    check("back_load", {busy, g_ready}, 2'b01);
  endtask

  initial begin
    rst      = 1'b1;
    g_valid  = 1'b0;
    g_data   = '0;
    dx_ready = 1'b0;
    repeat (2) @(negedge clk);
    check("reset_state", outs(), 0);
    rst = 1'b0;

    set_rand();
    load_g(0);
    @(negedge clk);
    g_valid = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("mid_reset_1", outs(), 0);
    @(negedge clk);
    check("mid_reset_2", outs(), 0);
    rst = 1'b0;

    set_all(16'h0000, 16'h0000);
    for (int k = 0; k < N; k++) wmem[k*N+k] = 16'h0100;
    gv[0] = 16'h0100;
    gv[1] = 16'h0200;
    gv[2] = 16'hFF00;
    gv[3] = 16'h0080;
    run_vec(0, 0);

    set_all(16'h0080, 16'h0100);
    run_vec(0, 0);

    set_all(16'h0000, 16'h0000);
    wmem[0] = 16'h0001;
    gv[0]   = 16'hFF80;
    run_vec(0, 0);

    set_all(16'h0080, 16'h0100);
    run_vec(0, 10);

    set_all(16'h7F00, 16'h0100);
    run_vec(0, 0);

    set_rand();
    run_vec(1, 0);

    for (int r = 0; r < 4; r++) begin
      set_rand();
      run_vec(r[0], 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
